// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit little-endian instruction words, writes them
// into the instruction SRAM, and releases the core once the image checksum matches.
module imem_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr,
   output logic [DATA_W-1:0] init_data,
   output logic              core_run,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int NBYTES = DATA_W / 8;
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_HDR   = 3'd0,
      S_DATA  = 3'd1,
      S_WRITE = 3'd2,
      S_CSUM  = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t            state_reg, state_next;

   logic [CNT_W-1:0]  n_reg;
   logic [CNT_W-1:0]  words_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [1:0]        byte_idx_reg;
   logic [7:0]        csum_reg;
   logic [DATA_W-1:0] word_reg;
   logic [DATA_W-1:0] word_next;
   logic [ADDR_W-1:0] init_addr_reg;
   logic [DATA_W-1:0] init_data_reg;
   logic [NBYTES-1:0] lane_we;

   logic              accept;
   logic              data_accept;
   logic              last_byte;
   logic              last_word;
   logic              hdr_ok;
   logic [CNT_W-1:0]  hdr_words;
   logic [CNT_W-1:0]  words_inc;

   assign accept      = in_valid & in_ready;
   assign data_accept = accept & (state_reg == S_DATA);
   assign last_byte   = (byte_idx_reg == 2'(NBYTES - 1));
   assign words_inc   = words_reg + 1'b1;
   assign last_word   = (words_inc == n_reg);

   // A zero header stands for a full image of DEPTH words.
   assign hdr_ok    = (int'(in_data) <= DEPTH);
   assign hdr_words = (in_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(in_data);

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_lane
         assign lane_we[gi]             = data_accept && (byte_idx_reg == 2'(gi));
         assign word_next[8*gi +: 8]    = lane_we[gi] ? in_data : word_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_HDR;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_HDR: begin
            if (accept) begin
               state_next = hdr_ok ? S_DATA : S_ERR;
            end
         end
         S_DATA: begin
            if (accept && last_byte) begin
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            state_next = last_word ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (accept) begin
               state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
            end
         end
         S_DONE, S_ERR: begin
            if (start) begin
               state_next = S_HDR;
            end
         end
         default: state_next = S_HDR;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      init_we   = 1'b0;
      core_run  = 1'b0;
      load_done = 1'b0;
      load_err  = 1'b0;
      case (state_reg)
         S_HDR, S_DATA, S_CSUM: in_ready = 1'b1;
         S_WRITE:               init_we  = 1'b1;
         S_DONE: begin
            core_run  = 1'b1;
            load_done = 1'b1;
         end
         S_ERR:                 load_err = 1'b1;
         default: ;
      endcase
   end

   // The SRAM port registers are loaded with the completed word on its last byte, so they
   // are already stable during WRITE and hold between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_reg         <= '0;
         words_reg     <= '0;
         addr_reg      <= '0;
         byte_idx_reg  <= '0;
         csum_reg      <= '0;
         word_reg      <= '0;
         init_addr_reg <= '0;
         init_data_reg <= '0;
      end else begin
         case (state_reg)
            S_HDR: begin
               if (accept && hdr_ok) begin
                  n_reg        <= hdr_words;
                  words_reg    <= '0;
                  addr_reg     <= '0;
                  byte_idx_reg <= '0;
                  csum_reg     <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  word_reg     <= word_next;
                  csum_reg     <= csum_reg ^ in_data;
                  byte_idx_reg <= byte_idx_reg + 1'b1;
                  if (last_byte) begin
                     init_addr_reg <= addr_reg;
                     init_data_reg <= word_next;
                  end
               end
            end
            S_WRITE: begin
               words_reg <= words_inc;
               // Stop at N-1 so a full DEPTH image never wraps the address.
               if (!last_word) begin
                  addr_reg <= addr_reg + 1'b1;
               end
            end
            S_DONE, S_ERR: begin
               if (start) begin
                  words_reg <= '0;
                  addr_reg  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign init_addr    = init_addr_reg;
   assign init_data    = init_data_reg;
   assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a table of image loads checked against a byte-level image model,
// plus hand-written sequences for reset during a load and start arriving in DONE.
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic              start    = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data  = 8'h00;
   logic              in_ready;
   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic [DATA_W-1:0] init_data;
   logic              core_run;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .init_we     (init_we),
      .init_addr   (init_addr),
      .init_data   (init_data),
      .core_run    (core_run),
      .load_done   (load_done),
      .load_err    (load_err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Write-port monitor: captures every SRAM write and counts handshake/hold violations.
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [DATA_W-1:0] wr_data_q[$];
   time               wr_time_q[$];
   bit                mon_on = 1'b0;
   int                rdy_bad = 0;
   int                hold_bad = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [DATA_W-1:0] last_data = '0;

   always @(negedge clk) begin
      if (reset) begin
         if (init_we) begin
            wr_addr_q.push_back(init_addr);
            wr_data_q.push_back(init_data);
            wr_time_q.push_back($time);
         end else if (init_addr !== last_addr || init_data !== last_data) begin
            hold_bad <= hold_bad + 1;
         end
         if (mon_on && (in_ready !== !init_we)) rdy_bad <= rdy_bad + 1;
      end
      last_addr <= init_addr;
      last_data <= init_data;
   end

   logic [7:0] plan_b [8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00};

   task automatic send(input logic [7:0] b, input int gap_pct);
      bit acc = 1'b0;
      for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int c = 0; c < 50 && !acc; c++) begin
         acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) begin
         checks++;
         $display("FAIL send_timeout: byte 0x%0h in_ready stayed 0, expected 1", b);
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_start(input string tag);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " start in_ready"}, 64'(in_ready), 64'd1);
      check({tag, " start done"}, 64'(load_done), 64'd0);
      check({tag, " start err"}, 64'(load_err), 64'd0);
      check({tag, " start wl"}, 64'(words_loaded), 64'd0);
      check({tag, " start core_run"}, 64'(core_run), 64'd0);
   endtask

   task automatic run_load(input logic [7:0] hdr, input bit plan, input bit bad_csum,
                           input int gap_pct, input bit start_mid, input bit e_done,
                           input bit e_err, input int e_wl, input string tag);
      logic [7:0] bytes[$];
      logic [7:0] sum;
      logic [7:0] cb;
      logic [DATA_W-1:0] exp_word;
      int n, expn, nw, wb, rb, hb;
      bit valid;

      pulse_start(tag);
      valid = (int'(hdr) <= DEPTH);
      n     = (hdr == 8'd0) ? DEPTH : int'(hdr);
      expn  = valid ? n : 0;
      sum   = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
         bytes.push_back(plan ? plan_b[i % 8] : 8'($urandom));
         sum ^= bytes[i];
      end
      cb = bad_csum ? ((sum == 8'h00) ? 8'hFF : 8'h00) : sum;

      wb = wr_addr_q.size();
      rb = rdy_bad;
      hb = hold_bad;
      mon_on = 1'b1;
      send(hdr, gap_pct);
      if (valid) begin
         for (int i = 0; i < 4 * n; i++) begin
            if (start_mid && i == 2) start = 1'b1;
            send(bytes[i], gap_pct);
            start = 1'b0;
         end
         send(cb, gap_pct);
      end
      mon_on = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      check({tag, " load_done"}, 64'(load_done), 64'(e_done));
      check({tag, " load_err"}, 64'(load_err), 64'(e_err));
      check({tag, " core_run"}, 64'(core_run), 64'(e_done));
      check({tag, " words_loaded"}, 64'(words_loaded), 64'(e_wl));
      check({tag, " in_ready idle"}, 64'(in_ready), 64'd0);

      nw = wr_addr_q.size() - wb;
      check({tag, " write count"}, 64'(nw), 64'(expn));
      for (int i = 0; i < nw && i < expn; i++) begin
         exp_word = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
         check($sformatf("%s wr%0d addr", tag, i), 64'(wr_addr_q[wb+i]), 64'(i));
         check($sformatf("%s wr%0d data", tag, i), 64'(wr_data_q[wb+i]), 64'(exp_word));
      end
      if (gap_pct == 0 && expn >= 2 && nw >= 2)
         check({tag, " word period"}, 64'(wr_time_q[wb+1] - wr_time_q[wb]), 64'd50);
      check({tag, " in_ready vs write"}, 64'(rdy_bad - rb), 64'd0);
      check({tag, " port hold"}, 64'(hold_bad - hb), 64'd0);
      $display("load %s: hdr=0x%02h writes=%0d done=%0d err=%0d wl=%0d", tag, hdr, nw,
               load_done, load_err, words_loaded);
   endtask

   typedef struct {
      logic [7:0] hdr;
      bit         plan;
      bit         bad;
      int         gap;
      bit         smid;
      bit         e_done;
      bit         e_err;
      int         e_wl;
   } vec_t;

   vec_t vt[8];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'h02, 1'b1, 1'b0, 0,  1'b0, 1'b1, 1'b0, 2};
      vt[1] = '{8'h02, 1'b1, 1'b1, 0,  1'b0, 1'b0, 1'b1, 2};
      vt[2] = '{8'h21, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b1, 0};
      vt[3] = '{8'h00, 1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b0, 32};
      vt[4] = '{8'h02, 1'b1, 1'b0, 50, 1'b0, 1'b1, 1'b0, 2};
      vt[5] = '{8'h01, 1'b0, 1'b0, 30, 1'b1, 1'b1, 1'b0, 1};
      vt[6] = '{8'h20, 1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b1, 32};
      vt[7] = '{8'h03, 1'b0, 1'b0, 50, 1'b1, 1'b1, 1'b0, 3};

      #2 reset = 1'b0;
      #1;
      check("rst in_ready", 64'(in_ready), 64'd1);
      check("rst init_we", 64'(init_we), 64'd0);
      check("rst init_addr", 64'(init_addr), 64'd0);
      check("rst init_data", 64'(init_data), 64'd0);
      check("rst core_run", 64'(core_run), 64'd0);
      check("rst load_done", 64'(load_done), 64'd0);
      check("rst load_err", 64'(load_err), 64'd0);
      check("rst words_loaded", 64'(words_loaded), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int v = 0; v < 8; v++)
         run_load(vt[v].hdr, vt[v].plan, vt[v].bad, vt[v].gap, vt[v].smid,
                  vt[v].e_done, vt[v].e_err, vt[v].e_wl, $sformatf("vec%0d", v));

      // Reset lands while the third data byte is on the bus.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send(8'h02, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      in_valid = 1'b1;
      in_data  = 8'h33;
      #1 reset = 1'b0;
      #1;
      check("midrst in_ready", 64'(in_ready), 64'd1);
      check("midrst init_we", 64'(init_we), 64'd0);
      check("midrst init_addr", 64'(init_addr), 64'd0);
      check("midrst init_data", 64'(init_data), 64'd0);
      check("midrst core_run", 64'(core_run), 64'd0);
      check("midrst words_loaded", 64'(words_loaded), 64'd0);
      $display("midrst: in_ready=%0d core_run=%0d wl=%0d", in_ready, core_run, words_loaded);
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      run_load(8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1, "after_rst");

      // In DONE: byte and start together; the byte must be dropped.
      in_valid = 1'b1;
      in_data  = 8'h01;
      start    = 1'b1;
      #1;
      check("done_start in_ready before", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      check("done_start in_ready", 64'(in_ready), 64'd1);
      check("done_start core_run", 64'(core_run), 64'd0);
      check("done_start load_done", 64'(load_done), 64'd0);
      check("done_start words_loaded", 64'(words_loaded), 64'd0);
      $display("done_start: in_ready=%0d core_run=%0d", in_ready, core_run);
      run_load(8'h02, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 2, "after_done_start");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
